// File: rtl/sprite_blitter.sv
// Copies a rectangular RGB565 sprite from ROM into a framebuffer, clipping at the right and bottom edges.
// Optional: define BLIT_TRANSPARENCY_EN to skip pixels whose color equals KEY_COLOR.
module sprite_blitter #(
    parameter int          FB_W      = 320,
    parameter int          FB_H      = 240,
    parameter logic [15:0] KEY_COLOR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [8:0]  pos_x,
    input  logic [8:0]  pos_y,
    input  logic [8:0]  spr_width,
    input  logic [8:0]  spr_height,
    output logic [16:0] spr_pixel,
    input  logic [15:0] spr_color,
    output logic [16:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [9:0] FB_W_L = 10'(FB_W);
    localparam logic [9:0] FB_H_L = 10'(FB_H);

    state_t      state_r, next_state_s;
    logic [8:0]  pos_x_r, pos_y_r, width_r, height_r;
    logic [16:0] idx_r;
    logic [8:0]  col_r, row_r;
    logic [16:0] fb_addr_r;
    logic [15:0] fb_data_r;
    logic        fb_valid_r, busy_r, done_r;

    logic [9:0]  col_sum_s, row_sum_s;
    logic [16:0] addr_full_s;
    logic        clip_s, skip_s, last_s;
    logic        load_s, capture_s, advance_s;

    // Framebuffer coordinates are summed at 10 bits so an off-screen pixel can never wrap back on-screen
    always_comb begin
        col_sum_s   = {1'b0, pos_x_r} + {1'b0, col_r};
        row_sum_s   = {1'b0, pos_y_r} + {1'b0, row_r};
        addr_full_s = 17'(row_sum_s) * 17'(FB_W) + 17'(col_sum_s);
        clip_s      = (col_sum_s >= FB_W_L) || (row_sum_s >= FB_H_L);
        last_s      = (col_r == width_r - 9'd1) && (row_r == height_r - 9'd1);
    end

`ifdef BLIT_TRANSPARENCY_EN
    assign skip_s = clip_s || (spr_color == KEY_COLOR);
`else
    assign skip_s = clip_s;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                    if ((spr_width == 9'd0) || (spr_height == 9'd0)) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (!skip_s) begin
                    capture_s    = 1'b1;
                    next_state_s = WRITE;
                end else begin
                    advance_s    = 1'b1;
                    next_state_s = last_s ? DONE : FETCH;
                end
            end
            WRITE: begin
                if (fb_ready) begin
                    advance_s    = 1'b1;
                    next_state_s = last_s ? DONE : FETCH;
                end else begin
                    next_state_s = WRITE;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Latched sprite geometry, pixel walker and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_r    <= 9'd0;
            pos_y_r    <= 9'd0;
            width_r    <= 9'd0;
            height_r   <= 9'd0;
            idx_r      <= 17'd0;
            col_r      <= 9'd0;
            row_r      <= 9'd0;
            fb_addr_r  <= 17'd0;
            fb_data_r  <= 16'd0;
            fb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (load_s) begin
                pos_x_r  <= pos_x;
                pos_y_r  <= pos_y;
                width_r  <= spr_width;
                height_r <= spr_height;
                idx_r    <= 17'd0;
                col_r    <= 9'd0;
                row_r    <= 9'd0;
            end else if (advance_s) begin
                idx_r <= idx_r + 17'd1;
                if (col_r == width_r - 9'd1) begin
                    col_r <= 9'd0;
                    row_r <= row_r + 9'd1;
                end else begin
                    col_r <= col_r + 9'd1;
                end
            end
            // Address and data are frozen for the whole WRITE state
            if (capture_s) begin
                fb_addr_r <= addr_full_s;
                fb_data_r <= spr_color;
            end
            fb_valid_r <= (next_state_s == WRITE);
            busy_r     <= (next_state_s != IDLE);
            done_r     <= (next_state_s == DONE);
        end
    end

    assign spr_pixel = idx_r;
    assign fb_addr   = fb_addr_r;
    assign fb_data   = fb_data_r;
    assign fb_valid  = fb_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
